matrix_scan_engine: RTL and testbench

MATRIX_SCAN_ENGINE -- requirements
Module: matrix_scan_engine

---
 rtl/matrix_scan_pkg.sv | 18 +
 rtl/matrix_event_fifo.sv | 53 +++++
 rtl/matrix_scan_engine.sv | 138 +++++++++++++
 tb/tb_matrix_scan_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_pkg.sv
// Shared types for the keyboard matrix scanner: scan FSM states and queued key events.
package matrix_scan_pkg;

  // Wide enough for matrices up to 256 keys; the engine uses the low bits only.
  localparam int unsigned EVT_IDX_W = 8;

  typedef enum logic [1:0] {
    SETTLE,
    SCAN_COL,
    ADVANCE
  } scan_state_e;

  typedef struct packed {
    logic [EVT_IDX_W-1:0] index;
    logic                 press;
  } key_evt_t;

endpackage

// File: rtl/matrix_event_fifo.sv
// First-word-fall-through key event queue; head holds the last popped entry while empty.
module matrix_event_fifo
  import matrix_scan_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  key_evt_t data,
  input  logic     pop,
  output logic     valid,
  output logic     full,
  output key_evt_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  key_evt_t        mem [DEPTH];
  key_evt_t        last_evt;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            empty;
  logic            pop_fire;
  logic            wr_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_fire = pop && !empty;
  // A push into a full queue is still accepted when the head leaves in the same cycle.
  assign wr_en    = push && (!full || pop_fire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_evt <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_fire) begin
        last_evt <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign valid = !empty;
  assign head  = empty ? last_evt : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/matrix_scan_engine.sv
// Keyboard matrix scanner with per-key debounce and an event queue.
// MATRIX_SCAN_RELEASE_EVT_EN: when defined, release events are queued as well as presses.
module matrix_scan_engine
  import matrix_scan_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned IW            = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS-1:0]      row_out,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [IW-1:0]        evt_index,
  output logic                 evt_press,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow
);

  localparam int unsigned KEYS = ROWS * COLS;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW   = $clog2(DEBOUNCE_SCANS + 1);

  scan_state_e     state, state_next;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [SW-1:0]   settle_cnt;
  logic [COLS-1:0] col_meta, col_sync;
  logic [KEYS-1:0] keys;
  logic [DW-1:0]   deb_cnt [KEYS];

  logic [IW-1:0]   idx;
  logic            sample, differ, decide, enq, pop, fifo_full;
  key_evt_t        evt, head;

  always_comb begin
    state_next = state;
    case (state)
      SETTLE:   if (settle_cnt == SW'(SCAN_DIV - 1)) state_next = SCAN_COL;
      SCAN_COL: if (col == CW'(COLS - 1)) state_next = ADVANCE;
      ADVANCE:  state_next = SETTLE;
      default:  state_next = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SETTLE;
      row        <= '0;
      col        <= '0;
      settle_cnt <= '0;
      col_meta   <= '0;
      col_sync   <= '0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
      state    <= state_next;
      case (state)
        SETTLE: begin
          settle_cnt <= (state_next == SCAN_COL) ? '0 : settle_cnt + SW'(1);
          col        <= '0;
        end
        SCAN_COL: col <= col + CW'(1);
        ADVANCE:  row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
        default:  col <= '0;
      endcase
    end
  end

  always_comb begin
    idx    = IW'(32'(row) * COLS + 32'(col));
    sample = col_sync[col];
    differ = (sample != keys[idx]);
    decide = (state == SCAN_COL) && differ &&
             ((deb_cnt[idx] + DW'(1)) == DW'(DEBOUNCE_SCANS));
`ifdef MATRIX_SCAN_RELEASE_EVT_EN
    enq    = decide;
`else
    enq    = decide && sample;
`endif
    evt       = '0;
    evt.index = EVT_IDX_W'(idx);
    evt.press = sample;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keys <= '0;
      for (int unsigned k = 0; k < KEYS; k++) deb_cnt[k] <= '0;
    end else if (state == SCAN_COL) begin
      if (!differ) begin
        deb_cnt[idx] <= '0;
      end else if (decide) begin
        deb_cnt[idx] <= '0;
        keys[idx]    <= sample;
      end else begin
        deb_cnt[idx] <= deb_cnt[idx] + DW'(1);
      end
    end
  end

  matrix_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .data  (evt),
    .pop   (evt_ready),
    .valid (evt_valid),
    .full  (fifo_full),
    .head  (head)
  );

  assign pop       = evt_valid && evt_ready;
  assign overflow  = enq && fifo_full && !pop;
  assign row_out   = ROWS'(1) << row;
  assign key_state = keys;
  assign evt_index = head.index[IW-1:0];

`ifdef MATRIX_SCAN_RELEASE_EVT_EN
  assign evt_press = head.press;
  logic unused_head;
  assign unused_head = ^head.index[EVT_IDX_W-1:IW];
`else
  assign evt_press = 1'b1;
  logic unused_head;
  assign unused_head = ^{head.index[EVT_IDX_W-1:IW], head.press};
`endif

endmodule

// File: tb/tb_matrix_scan_engine.sv
// Scoreboard bench for matrix_scan_engine: frame-level key model feeds an expected-event queue.
module tb_matrix_scan_engine;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SDIV  = 8;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int KEYS  = ROWS * COLS;
  localparam int RP    = SDIV + COLS + 1;
  localparam int FRAME = RP * ROWS;
`ifdef MATRIX_SCAN_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            evt_ready = 1'b0;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_out;
  logic            evt_valid, evt_press, overflow;
  logic [3:0]      evt_index;
  logic [KEYS-1:0] key_state;

  logic [KEYS-1:0] phys = '0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int ovf_seen = 0;
  int exp_ovf = 0;

  logic [KEYS-1:0] mstate = '0;
  int mcnt [KEYS];
  typedef struct {int idx; bit press;} ev_t;
  ev_t expq[$];
  ev_t got;

  matrix_scan_engine #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
    .evt_press(evt_press), .key_state(key_state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a driven row reflects its pressed keys onto the columns.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_out[r]) col_in = col_in | phys[r*COLS +: COLS];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  logic       pv_hold = 1'b0;
  logic [3:0] p_idx;
  logic       p_press;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv_hold = 1'b0;
    end else begin
      if (overflow) ovf_seen++;
      if (pv_hold && evt_valid) begin
        chk("hold_index", evt_index, p_idx);
        chk("hold_press", evt_press, p_press);
      end
      if (evt_valid && evt_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got index %0d press %0d, expected none", evt_index, evt_press);
        end else begin
          got = expq.pop_front();
          chk("evt_index", evt_index, got.idx);
          chk("evt_press", evt_press, got.press);
        end
      end
      pv_hold = evt_valid && !evt_ready;
      p_idx   = evt_index;
      p_press = evt_press;
    end
  end

  task automatic set_mode(input int m);
    rdy_mode  = m;
    evt_ready = (m == 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rdy_mode == 2) evt_ready = cyc[0] ? 1'b1 : 1'($urandom);
    chk("row_out", row_out, 1 << ((cyc % FRAME) / RP));
  endtask

  // One full scan: each key is sampled once, in ascending index order.
  task automatic model_frame();
    int cap = DEPTH - expq.size();
    for (int k = 0; k < KEYS; k++) begin
      if (phys[k] != mstate[k]) begin
        mcnt[k]++;
        if (mcnt[k] == DEB) begin
          mcnt[k] = 0;
          mstate[k] = phys[k];
          if (phys[k] || REL) begin
            if (rdy_mode == 0 && cap <= 0) exp_ovf++;
            else begin
              expq.push_back('{k, phys[k]});
              cap--;
            end
          end
        end
      end else begin
        mcnt[k] = 0;
      end
    end
  endtask

  task automatic frame(input logic [KEYS-1:0] p, input int lat_key);
    int s = (lat_key / COLS) * RP + SDIV + (lat_key % COLS);
    chk("key_state", key_state, mstate);
    phys = p;
    model_frame();
    for (int i = 1; i <= FRAME; i++) begin
      step();
      if (lat_key >= 0 && i == s)     chk("latency_before", evt_valid, 0);
      if (lat_key >= 0 && i == s + 1) chk("latency_after", evt_valid, 1);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    mstate = '0;
    foreach (mcnt[k]) mcnt[k] = 0;
    expq.delete();
    chk("rst_valid", evt_valid, 0);
    chk("rst_key_state", key_state, 0);
    chk("rst_row_out", row_out, 1);
    chk("rst_index", evt_index, 0);
    chk("rst_press", evt_press, REL ? 0 : 1);
    chk("rst_overflow", overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [KEYS-1:0] p;
    foreach (mcnt[k]) mcnt[k] = 0;
    set_mode(1);
    do_reset(3);

    frame('0, -1);

    p = KEYS'(1) << 6;
    frame(p, -1);
    frame(p, -1);
    frame(p, 6);

    p[5] = 1'b1;
    frame(p, -1);
    frame(p, -1);
    p[5] = 1'b0;
    frame(p, -1);
    p[5] = 1'b1;
    repeat (3) frame(p, -1);

    p = p | 16'h000B;
    repeat (4) frame(p, -1);

    set_mode(0);
    p = p | 16'h1F00;
    repeat (3) frame(p, -1);
    frame(p, -1);
    chk("overflow_pulses", ovf_seen, exp_ovf);
    set_mode(1);
    frame(p, -1);
    frame(p, -1);

    do_reset(1);
    set_mode(0);
    p = 16'h0003;
    frame(p, -1);
    p[9] = 1'b1;
    frame(p, -1);
    frame(p, -1);
    chk("queued_before_reset", evt_valid, 1);
    do_reset(1);
    set_mode(1);
    repeat (4) frame(p, -1);

    set_mode(2);
    for (int f = 0; f < 16; f++) begin
      p = p ^ (KEYS'($urandom) & KEYS'($urandom));
      frame(p, -1);
    end
    set_mode(1);
    repeat (2) frame(p, -1);
    chk("queue_drained", expq.size(), 0);
    chk("overflow_total", ovf_seen, exp_ovf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
